// File: rtl/line_rasterizer_pkg.sv
// line_rasterizer_pkg: vertex field layout, fixed-point format and FSM encodings
package line_rasterizer_pkg;

   localparam int FRAC_BITS = 7;
   localparam int X_LSB     = 16;
   localparam int Y_LSB     = 32;
   localparam int COLOR_LSB = 48;

   localparam logic [1:0] WAIT_A = 2'd0;
   localparam logic [1:0] WAIT_B = 2'd1;
   localparam logic [1:0] SETUP  = 2'd2;
   localparam logic [1:0] DRAW   = 2'd3;

endpackage

// File: rtl/line_rasterizer_vertex_to_pixel.sv
// vertex_to_pixel: round a signed Q8.7 vertex position to 9-bit signed pixel coordinates
module vertex_to_pixel
   import line_rasterizer_pkg::*;
(
   input  logic        [15:0] x_q,
   input  logic        [15:0] y_q,
   output logic signed [8:0]  x,
   output logic signed [8:0]  y
);

   localparam logic signed [15:0] HALF = 16'sd1 <<< (FRAC_BITS - 1);

   // round to nearest in 16-bit signed arithmetic, then keep the low 9 bits
   always_comb begin
      x = 9'(($signed(x_q) + HALF) >>> FRAC_BITS);
      y = 9'(($signed(y_q) + HALF) >>> FRAC_BITS);
   end

endmodule

// File: rtl/line_rasterizer.sv
// line_rasterizer: pair vertices into segments and walk them with Bresenham, one pixel per cycle
module line_rasterizer
   import line_rasterizer_pkg::*;
#(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [63:0] Vertex,
   input  logic        NewVertex,
   output logic        stall,
   input  logic        strip_mode,
   input  logic        prim_restart,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic [8:0]  pixel_x,
   output logic [8:0]  pixel_y,
   output logic [15:0] pixel_color
);

   localparam logic [9:0] W_LIM = 10'(SCREEN_W);
   localparam logic [9:0] H_LIM = 10'(SCREEN_H);

   logic [1:0]         state;
   logic [15:0]        xq0, yq0, xq1, yq1, col0, col1;
   logic signed [8:0]  x0, y0, x1, y1, cur_x, cur_y;
   logic [9:0]         dx;
   logic signed [10:0] dy;
   logic signed [11:0] err;
   logic               sx, sy;
   logic               accept, step, at_end, step_x, step_y;
   logic signed [9:0]  ddx, ddy;
   logic [9:0]         adx, ady;
   logic signed [10:0] dy_n;
   logic signed [12:0] e2;
   logic signed [11:0] err_n;
   logic               unused_bits;

   vertex_to_pixel u_start (.x_q(xq0), .y_q(yq0), .x(x0), .y(y0));
   vertex_to_pixel u_end   (.x_q(xq1), .y_q(yq1), .x(x1), .y(y1));

   assign unused_bits = ^Vertex[15:0];
   assign stall       = (state == SETUP) | (state == DRAW);
   assign accept      = NewVertex & ~stall;
   assign pixel_valid = (state == DRAW) & ~cur_x[8] & ~cur_y[8] &
                        ({2'b0, cur_x[7:0]} < W_LIM) & ({2'b0, cur_y[7:0]} < H_LIM);
   assign pixel_x     = cur_x;
   assign pixel_y     = cur_y;
   assign pixel_color = col0;

   // segment setup terms and the Bresenham step decision for the current pixel
   always_comb begin
      ddx    = {x1[8], x1} - {x0[8], x0};
      ddy    = {y1[8], y1} - {y0[8], y0};
      adx    = ddx[9] ? -ddx : ddx;
      ady    = ddy[9] ? -ddy : ddy;
      dy_n   = -$signed({1'b0, ady});
      e2     = {err, 1'b0};
      step_x = e2 >= 13'(dy);
      step_y = e2 <= $signed({3'b0, dx});
      at_end = (cur_x == x1) && (cur_y == y1);
      step   = ~pixel_valid | pixel_ready;
      err_n  = err + (step_x ? 12'(dy) : 12'sd0) + (step_y ? $signed({2'b0, dx}) : 12'sd0);
   end

   // vertex pairing FSM and line walker; an out-of-bounds pixel still costs one DRAW cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= WAIT_A;
         xq0   <= '0;
         yq0   <= '0;
         xq1   <= '0;
         yq1   <= '0;
         col0  <= '0;
         col1  <= '0;
         cur_x <= '0;
         cur_y <= '0;
         dx    <= '0;
         dy    <= '0;
         err   <= '0;
         sx    <= 1'b0;
         sy    <= 1'b0;
      end else begin
         case (state)
            WAIT_A: if (accept) begin
               xq0   <= Vertex[X_LSB +: 16];
               yq0   <= Vertex[Y_LSB +: 16];
               col0  <= Vertex[COLOR_LSB +: 16];
               state <= WAIT_B;
            end
            WAIT_B: if (accept && prim_restart) begin
               xq0  <= Vertex[X_LSB +: 16];
               yq0  <= Vertex[Y_LSB +: 16];
               col0 <= Vertex[COLOR_LSB +: 16];
            end else if (accept) begin
               xq1   <= Vertex[X_LSB +: 16];
               yq1   <= Vertex[Y_LSB +: 16];
               col1  <= Vertex[COLOR_LSB +: 16];
               state <= SETUP;
            end else if (prim_restart) begin
               state <= WAIT_A;
            end
            SETUP: begin
               dx    <= adx;
               dy    <= dy_n;
               sx    <= ddx[9];
               sy    <= ddy[9];
               err   <= $signed({2'b0, adx}) + 12'(dy_n);
               cur_x <= x0;
               cur_y <= y0;
               state <= DRAW;
            end
            default: if (step) begin
               if (at_end) begin
                  if (strip_mode) begin
                     xq0  <= xq1;
                     yq0  <= yq1;
                     col0 <= col1;
                  end
                  state <= strip_mode ? WAIT_B : WAIT_A;
               end else begin
                  err <= err_n;
                  if (step_x) cur_x <= cur_x + (sx ? -9'sd1 : 9'sd1);
                  if (step_y) cur_y <= cur_y + (sy ? -9'sd1 : 9'sd1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer: directed vectors with hand-computed pixel streams for line_rasterizer
module tb_line_rasterizer;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [63:0] Vertex = '0;
   logic        NewVertex = 1'b0;
   logic        strip_mode = 1'b0;
   logic        prim_restart = 1'b0;
   logic        pixel_ready = 1'b1;
   logic        stall, pixel_valid;
   logic [8:0]  pixel_x, pixel_y;
   logic [15:0] pixel_color;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic [33:0] px_q[$];
   int          cy_q[$];

   line_rasterizer #(.SCREEN_W(160), .SCREEN_H(120)) dut (
      .CLK(CLK), .RST_N(RST_N), .Vertex(Vertex), .NewVertex(NewVertex), .stall(stall),
      .strip_mode(strip_mode), .prim_restart(prim_restart), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color)
   );

   always #5 CLK = ~CLK;

   // cycle counter
   always @(posedge CLK) cyc <= cyc + 1;

   // record every handshaken pixel and the cycle it appeared in
   always @(negedge CLK) if (pixel_valid && pixel_ready) begin
      px_q.push_back({pixel_x, pixel_y, pixel_color});
      cy_q.push_back(cyc);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] vert(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
      return {c, y, x, 16'h0};
   endfunction

   function automatic logic [33:0] px(input int x, input int y, input logic [15:0] c);
      return {x[8:0], y[8:0], c};
   endfunction

   task automatic send(input logic [63:0] v);
      int n = 0;
      Vertex = v;
      NewVertex = 1'b1;
      @(negedge CLK);
      while (stall && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check("accept", stall, 0);
      acc_cyc = cyc;
      @(posedge CLK);
      #1 NewVertex = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      @(negedge CLK);
      while (stall && n < 200) begin
         n++;
         @(negedge CLK);
      end
      check("done", stall, 0);
      @(posedge CLK);
      #1;
   endtask

   task automatic check_seg(input string tag, input int n, input logic [33:0] e[8], input bit timed);
      check({tag, "_count"}, px_q.size(), n);
      for (int i = 0; i < n; i++) begin
         logic [33:0] g;
         int c;
         g = '1;
         c = -1;
         if (i < px_q.size()) begin
            g = px_q[i];
            c = cy_q[i];
         end
         check(tag, g, e[i]);
         if (timed) check({tag, "_cyc"}, c, acc_cyc + 2 + i);
      end
      px_q.delete();
      cy_q.delete();
   endtask

   initial begin
      int n;
      #12;
      check("rst_stall", stall, 0);
      check("rst_valid", pixel_valid, 0);
      check("rst_x", pixel_x, 0);
      check("rst_y", pixel_y, 0);
      check("rst_color", pixel_color, 0);
      @(posedge CLK);
      #1 RST_N = 1'b1;
      @(posedge CLK);
      #1;

      send(vert(16'h0000, 16'h0000, 16'hF800));
      send(vert(16'h0180, 16'h0000, 16'hF800));
      wait_done(n);
      check("horiz_stall", n, 5);
      check_seg("horiz", 4, '{px(0,0,16'hF800), px(1,0,16'hF800), px(2,0,16'hF800), px(3,0,16'hF800),
                              '0, '0, '0, '0}, 1'b1);

      send(vert(16'h0000, 16'h0000, 16'h07E0));
      send(vert(16'h0080, 16'h0180, 16'h0BAD));
      wait_done(n);
      check_seg("steep", 4, '{px(0,0,16'h07E0), px(0,1,16'h07E0), px(1,2,16'h07E0), px(1,3,16'h07E0),
                              '0, '0, '0, '0}, 1'b1);

      send(vert(16'h00C0, 16'h0000, 16'h1111));
      send(vert(16'h00C0, 16'h0000, 16'h2222));
      wait_done(n);
      check("degen_stall", n, 2);
      check_seg("degen", 1, '{px(2,0,16'h1111), '0, '0, '0, '0, '0, '0, '0}, 1'b1);

      send(vert(16'h0000, 16'h0000, 16'h0F0F));
      send(vert(16'h0180, 16'h0000, 16'h0F0F));
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1 pixel_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("bp_valid", pixel_valid, 1);
         check("bp_x", pixel_x, 1);
         check("bp_stall", stall, 1);
         @(posedge CLK);
         #1;
         if (i == 2) pixel_ready = 1'b1;
      end
      wait_done(n);
      check_seg("bp", 4, '{px(0,0,16'h0F0F), px(1,0,16'h0F0F), px(2,0,16'h0F0F), px(3,0,16'h0F0F),
                           '0, '0, '0, '0}, 1'b0);

      send(vert(16'h4F00, 16'h0000, 16'h7777));
      send(vert(16'h5080, 16'h0000, 16'h7777));
      wait_done(n);
      check("clip_stall", n, 5);
      check_seg("clip", 2, '{px(158,0,16'h7777), px(159,0,16'h7777), '0, '0, '0, '0, '0, '0}, 1'b1);

      strip_mode = 1'b1;
      send(vert(16'h0000, 16'h0000, 16'h001F));
      send(vert(16'h0100, 16'h0000, 16'h1234));
      send(vert(16'h0100, 16'h0100, 16'hABCD));
      wait_done(n);
      check("strip_stall", n, 4);
      check_seg("strip", 6, '{px(0,0,16'h001F), px(1,0,16'h001F), px(2,0,16'h001F),
                              px(2,0,16'h1234), px(2,1,16'h1234), px(2,2,16'h1234), '0, '0}, 1'b0);

      prim_restart = 1'b1;
      @(posedge CLK);
      #1 prim_restart = 1'b0;
      strip_mode = 1'b0;
      send(vert(16'h0280, 16'h0280, 16'h5555));
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("restart_stall", stall, 0);
      end
      check("restart_none", px_q.size(), 0);
      @(posedge CLK);
      #1;
      send(vert(16'h0380, 16'h0280, 16'h6666));
      wait_done(n);
      check_seg("restart", 3, '{px(5,5,16'h5555), px(6,5,16'h5555), px(7,5,16'h5555),
                                '0, '0, '0, '0, '0}, 1'b1);

      send(vert(16'h0000, 16'h0000, 16'h4444));
      send(vert(16'h2000, 16'h0000, 16'h4444));
      repeat (4) @(posedge CLK);
      #1;
      Vertex = vert(16'h0100, 16'h0100, 16'h9999);
      NewVertex = 1'b1;
      #2 RST_N = 1'b0;
      #1;
      check("midrst_stall", stall, 0);
      check("midrst_valid", pixel_valid, 0);
      repeat (2) @(posedge CLK);
      #1 NewVertex = 1'b0;
      px_q.delete();
      cy_q.delete();
      RST_N = 1'b1;
      repeat (10) @(negedge CLK);
      check("midrst_none", px_q.size(), 0);
      check("midrst_idle", stall, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
